// File: rtl/rgp16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rgp16_pkg
// Description : Shared constants and types for the RGP16 fetch/decode front
//               end. It holds the default word width, the NOP bubble word and
//               the encoding of the instruction assembler states.
// Revision    : 1.0 - initial release
// ============================================================================
package rgp16_pkg;

  localparam int          DEFAULT_WIDTH = 16;
  localparam logic [15:0] NOP_DEFAULT   = 16'h0F00;

  // These are the states of the instruction assembler.
  // S_FIRST is waiting for an opcode word.
  // S_SECOND holds an opcode and waits for its immediate word.
  typedef enum logic {
    S_FIRST  = 1'b0,
    S_SECOND = 1'b1
  } asm_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous word FIFO that sits between instruction memory and
//               the instruction assembler. The read data is presented
//               combinationally from the head entry.
// Ports       : clk, reset_n   - clock, asynchronous active-low reset
//               push, wr_data  - write request and data; ignored when full
//               pop, rd_data   - read request, head word; ignored when empty
//               clear          - synchronous discard of all contents
//               full, empty    - occupancy flags
//               count          - occupancy, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  input  logic                   clear,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/if_id_fetch_buf.sv
`default_nettype none
// ============================================================================
// Module      : if_id_fetch_buf
// Description : This is the IF/ID boundary buffer. A small word FIFO separates
//               fetch from decode. An assembler merges an opcode word with
//               EXT_BIT set and the following word, which becomes the
//               immediate. The buffer supports valid/ready fetch handshaking,
//               a decode stall and a branch flush.
// Ports       : clk, reset_n      - clock, asynchronous active-low reset
//               fetch_data_in     - word from instruction memory
//               fetch_valid_in    - fetch_data_in is valid
//               fetch_ready_out   - buffer accepts a word (combinational)
//               stall_in          - ID cannot accept; hold the outputs
//               flush_in          - discard all buffered and partial state
//               instruc_out       - instruction word (NOP when bubble)
//               imediat_out       - immediate word (0 for 1-word instr)
//               is_long_out       - output is a 2-word instruction
//               valid_out         - outputs carry a real instruction
//               count_out         - FIFO occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_fetch_buf
  import rgp16_pkg::*;
#(
  parameter int               WIDTH   = DEFAULT_WIDTH,
  parameter int               DEPTH   = 4,
  parameter int               EXT_BIT = 15,
  parameter logic [WIDTH-1:0] NOP     = WIDTH'(NOP_DEFAULT)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [WIDTH-1:0]       fetch_data_in,
  input  logic                   fetch_valid_in,
  output logic                   fetch_ready_out,
  input  logic                   stall_in,
  input  logic                   flush_in,
  output logic [WIDTH-1:0]       instruc_out,
  output logic [WIDTH-1:0]       imediat_out,
  output logic                   is_long_out,
  output logic                   valid_out,
  output logic [$clog2(DEPTH):0] count_out
);

  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] head_word;
  logic [WIDTH-1:0] hold_reg;
  asm_state_t       state;

  // Ready drops during a flush. Fetch then re-presents the word instead of
  // the word being silently discarded by the clear.
  assign fetch_ready_out = !fifo_full && !flush_in;
  assign push            = fetch_valid_in && fetch_ready_out;
  assign pop             = !fifo_empty && !stall_in && !flush_in;

  fetch_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wr_data (fetch_data_in),
    .pop     (pop),
    .rd_data (head_word),
    .clear   (flush_in),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count_out)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_FIRST;
      hold_reg    <= '0;
      instruc_out <= NOP;
      imediat_out <= '0;
      is_long_out <= 1'b0;
      valid_out   <= 1'b0;
    end else if (flush_in) begin
      state       <= S_FIRST;
      hold_reg    <= '0;
      instruc_out <= NOP;
      imediat_out <= '0;
      is_long_out <= 1'b0;
      valid_out   <= 1'b0;
    end else if (!stall_in) begin
      // Default to a bubble. A pop below may overwrite it.
      instruc_out <= NOP;
      imediat_out <= '0;
      is_long_out <= 1'b0;
      valid_out   <= 1'b0;
      if (pop) begin
        case (state)
          S_FIRST: begin
            if (head_word[EXT_BIT]) begin
              hold_reg <= head_word;
              state    <= S_SECOND;
            end else begin
              instruc_out <= head_word;
              valid_out   <= 1'b1;
            end
          end
          default: begin
            // The immediate word is taken as-is. Its EXT_BIT has no meaning.
            instruc_out <= hold_reg;
            imediat_out <= head_word;
            is_long_out <= 1'b1;
            valid_out   <= 1'b1;
            state       <= S_FIRST;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_id_fetch_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_fetch_buf
// Description : Directed, self-checking bench for if_id_fetch_buf. It covers
//               reset, 1-word and 2-word issue, stall backpressure, flush of a
//               half-assembled instruction, flush over stall, and an
//               asynchronous mid-operation reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_fetch_buf;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [W-1:0]  fetch_data_in;
  logic          fetch_valid_in;
  logic          fetch_ready_out;
  logic          stall_in;
  logic          flush_in;
  logic [W-1:0]  instruc_out;
  logic [W-1:0]  imediat_out;
  logic          is_long_out;
  logic          valid_out;
  logic [2:0]    count_out;

  int n_checks = 0;
  int n_fails  = 0;

  if_id_fetch_buf #(
    .WIDTH   (16),
    .DEPTH   (4),
    .EXT_BIT (15),
    .NOP     (16'h0F00)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .fetch_data_in   (fetch_data_in),
    .fetch_valid_in  (fetch_valid_in),
    .fetch_ready_out (fetch_ready_out),
    .stall_in        (stall_in),
    .flush_in        (flush_in),
    .instruc_out     (instruc_out),
    .imediat_out     (imediat_out),
    .is_long_out     (is_long_out),
    .valid_out       (valid_out),
    .count_out       (count_out)
  );

  always #5 clk = ~clk;

  // The output tuple is {instruc, imediat, is_long, valid}.
  logic [33:0] outs;
  assign outs = {instruc_out, imediat_out, is_long_out, valid_out};

  localparam logic [33:0] BUBBLE = {16'h0F00, 16'h0000, 1'b0, 1'b0};

  // This task advances one clock edge and then settles 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; fetch_data_in = '0; fetch_valid_in = 1'b0;
    stall_in = 1'b0; flush_in = 1'b0;
    tick(); tick();
    n_checks++;
    if (outs !== BUBBLE) begin
      n_fails++; $display("FAIL reset_outs: got %h expected %h", outs, BUBBLE);
    end
    n_checks++;
    if (count_out !== 3'd0) begin
      n_fails++; $display("FAIL reset_count: got %0d expected 0", count_out);
    end
    #2 reset_n = 1'b1;
    #1;
    n_checks++;
    if (fetch_ready_out !== 1'b1) begin
      n_fails++; $display("FAIL reset_ready: got %b expected 1", fetch_ready_out);
    end
    tick();
  endtask

  task automatic test_short();
    fetch_valid_in = 1'b1; fetch_data_in = 16'h0123;
    tick();
    n_checks++;
    if (outs !== BUBBLE || count_out !== 3'd1) begin
      n_fails++; $display("FAIL short_push: got %h cnt %0d expected %h cnt 1", outs, count_out, BUBBLE);
    end
    fetch_data_in = 16'h0456;
    tick();
    n_checks++;
    if (outs !== {16'h0123, 16'h0000, 1'b0, 1'b1}) begin
      n_fails++; $display("FAIL short_first: got %h expected 0123/0000/0/1", outs);
    end
    fetch_valid_in = 1'b0;
    tick();
    n_checks++;
    if (outs !== {16'h0456, 16'h0000, 1'b0, 1'b1}) begin
      n_fails++; $display("FAIL short_second: got %h expected 0456/0000/0/1", outs);
    end
    tick();
    n_checks++;
    if (outs !== BUBBLE || count_out !== 3'd0) begin
      n_fails++; $display("FAIL short_idle: got %h cnt %0d expected %h cnt 0", outs, count_out, BUBBLE);
    end
  endtask

  task automatic test_long();
    fetch_valid_in = 1'b1; fetch_data_in = 16'h8A10;
    tick();
    fetch_data_in = 16'h00F0;
    tick();
    n_checks++;
    if (outs !== BUBBLE) begin
      n_fails++; $display("FAIL long_bubble: got %h expected %h", outs, BUBBLE);
    end
    fetch_valid_in = 1'b0;
    tick();
    n_checks++;
    if (outs !== {16'h8A10, 16'h00F0, 1'b1, 1'b1}) begin
      n_fails++; $display("FAIL long_issue: got %h expected 8A10/00F0/1/1", outs);
    end
    tick();
    n_checks++;
    if (outs !== BUBBLE) begin
      n_fails++; $display("FAIL long_after: got %h expected %h", outs, BUBBLE);
    end
  endtask

  task automatic test_stall();
    logic [15:0] stall_words [6];
    logic [15:0] drain_words [4];
    logic [2:0]  exp_cnt;
    stall_words = '{16'h0022, 16'h0033, 16'h0044, 16'h0055, 16'h0066, 16'h0099};
    drain_words = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    fetch_valid_in = 1'b1; fetch_data_in = 16'h0777;
    tick();
    fetch_data_in = 16'h0011;
    tick();
    n_checks++;
    if (outs !== {16'h0777, 16'h0000, 1'b0, 1'b1} || count_out !== 3'd1) begin
      n_fails++; $display("FAIL stall_pre: got %h cnt %0d expected 0777/0000/0/1 cnt 1", outs, count_out);
    end
    stall_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      fetch_data_in = stall_words[i];
      tick();
      exp_cnt = (i >= 2) ? 3'd4 : 3'(i + 2);
      n_checks++;
      if (outs !== {16'h0777, 16'h0000, 1'b0, 1'b1} || count_out !== exp_cnt ||
          fetch_ready_out !== (exp_cnt != 3'd4)) begin
        n_fails++;
        $display("FAIL stall_hold[%0d]: got %h cnt %0d rdy %b expected 0777/0000/0/1 cnt %0d rdy %b",
                 i, outs, count_out, fetch_ready_out, exp_cnt, (exp_cnt != 3'd4));
      end
    end
    stall_in = 1'b0; fetch_valid_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (outs !== {drain_words[i], 16'h0000, 1'b0, 1'b1} || count_out !== 3'(3 - i)) begin
        n_fails++;
        $display("FAIL stall_drain[%0d]: got %h cnt %0d expected %h/0000/0/1 cnt %0d",
                 i, outs, count_out, drain_words[i], 3 - i);
      end
    end
    tick();
  endtask

  task automatic test_flush();
    fetch_valid_in = 1'b1; fetch_data_in = 16'h8A10;
    tick();
    fetch_valid_in = 1'b0;
    tick();
    flush_in = 1'b1; fetch_valid_in = 1'b1; fetch_data_in = 16'h00F0;
    #1;
    n_checks++;
    if (fetch_ready_out !== 1'b0) begin
      n_fails++; $display("FAIL flush_ready: got %b expected 0", fetch_ready_out);
    end
    tick();
    n_checks++;
    if (outs !== BUBBLE || count_out !== 3'd0) begin
      n_fails++; $display("FAIL flush_clear: got %h cnt %0d expected %h cnt 0", outs, count_out, BUBBLE);
    end
    flush_in = 1'b0; fetch_data_in = 16'h0111;
    tick();
    fetch_valid_in = 1'b0;
    tick();
    n_checks++;
    if (outs !== {16'h0111, 16'h0000, 1'b0, 1'b1}) begin
      n_fails++; $display("FAIL flush_next: got %h expected 0111/0000/0/1", outs);
    end
  endtask

  task automatic test_flush_stall();
    stall_in = 1'b1; fetch_valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fetch_data_in = 16'h0201 + 16'(i);
      tick();
    end
    n_checks++;
    if (count_out !== 3'd4 || fetch_ready_out !== 1'b0 || outs !== {16'h0111, 16'h0000, 1'b0, 1'b1}) begin
      n_fails++; $display("FAIL fs_full: got cnt %0d rdy %b outs %h expected cnt 4 rdy 0 0111/0000/0/1",
                          count_out, fetch_ready_out, outs);
    end
    flush_in = 1'b1; fetch_valid_in = 1'b0;
    tick();
    n_checks++;
    if (count_out !== 3'd0 || outs !== BUBBLE) begin
      n_fails++; $display("FAIL fs_flush: got cnt %0d outs %h expected cnt 0 %h", count_out, outs, BUBBLE);
    end
    flush_in = 1'b0; stall_in = 1'b0;
    tick();
    n_checks++;
    if (count_out !== 3'd0 || outs !== BUBBLE || fetch_ready_out !== 1'b1) begin
      n_fails++; $display("FAIL fs_after: got cnt %0d outs %h rdy %b expected cnt 0 %h rdy 1",
                          count_out, outs, fetch_ready_out, BUBBLE);
    end
  endtask

  task automatic test_async_reset();
    fetch_valid_in = 1'b1; fetch_data_in = 16'h8A10;
    tick();
    fetch_data_in = 16'h0301;
    tick();
    stall_in = 1'b1; fetch_data_in = 16'h0302;
    tick();
    fetch_data_in = 16'h0303;
    tick();
    n_checks++;
    if (count_out !== 3'd3) begin
      n_fails++; $display("FAIL ar_setup: got cnt %0d expected 3", count_out);
    end
    reset_n = 1'b0;
    #2;
    n_checks++;
    if (count_out !== 3'd0 || outs !== BUBBLE) begin
      n_fails++; $display("FAIL ar_immediate: got cnt %0d outs %h expected cnt 0 %h", count_out, outs, BUBBLE);
    end
    stall_in = 1'b0; fetch_valid_in = 1'b0;
    #2 reset_n = 1'b1;
    tick();
    fetch_valid_in = 1'b1; fetch_data_in = 16'h0500;
    tick();
    fetch_valid_in = 1'b0;
    tick();
    n_checks++;
    if (outs !== {16'h0500, 16'h0000, 1'b0, 1'b1} || count_out !== 3'd0) begin
      n_fails++; $display("FAIL ar_next: got %h cnt %0d expected 0500/0000/0/1 cnt 0", outs, count_out);
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_stall();
    test_flush();
    test_flush_stall();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
